// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM state encoding,
// beat counter width and a constant clog2 helper usable in parameter lists.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Beat counter is a fixed 8 bits so any BURST in 1..255 fits without wrap.
    localparam int BEAT_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// when searching last+1, last+2, ... with wrap-around modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int TAG_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [TAG_W-1:0] last,
    output logic [TAG_W-1:0] pick,
    output logic             any
);

    // cand[k] is the requester index examined at search position k.
    logic [TAG_W-1:0] cand [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand[gi] = TAG_W'((int'(last) + gi + 1) % N_REQ);
        end
    endgenerate

    // Scan candidates in rotating order; the earliest hit wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any && req[cand[k]]) begin
                any  = 1'b1;
                pick = cand[k];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO write port among N_REQ
// producers. A grantee keeps the port for up to BURST words; every word is
// tagged with its producer index and staged in a one-entry output register
// that drives the FIFO write pins whenever the FIFO is not full.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int BURST      = 4,
    localparam int TAG_W      = clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        fifo_we,
    output logic [TAG_W+DATA_WIDTH-1:0] fifo_d,
    input  logic                        fifo_full,
    output logic [TAG_W-1:0]            grant_id,
    output logic                        busy
);

    localparam logic [BEAT_W-1:0] BURST_LEN = BEAT_W'(BURST);
    // Reset "last" to the top index so requester 0 is searched first.
    localparam logic [TAG_W-1:0]  LAST_RST  = TAG_W'(N_REQ - 1);

    generate
        if (DATA_WIDTH + TAG_W > 16) begin : g_width_check
            $error("fifo_wr_arbiter: DATA_WIDTH + TAG_W exceeds the 16-bit FIFO word");
        end
        if (N_REQ < 2 || N_REQ > 8) begin : g_nreq_check
            $error("fifo_wr_arbiter: N_REQ must be in 2..8");
        end
        if (BURST < 1 || BURST > 255) begin : g_burst_check
            $error("fifo_wr_arbiter: BURST must be in 1..255");
        end
    endgenerate

    arb_state_e                  state_q, state_d;
    logic [TAG_W-1:0]            grant_q, grant_d;
    logic [TAG_W-1:0]            last_q, last_d;
    logic [BEAT_W-1:0]           beat_cnt_q, beat_cnt_d;
    logic [BEAT_W-1:0]           beat_inc;
    logic                        out_vld_q, out_vld_d;
    logic [TAG_W+DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic [TAG_W-1:0]            pick;
    logic                        pick_any;
    logic                        grant_ready;
    logic                        grant_valid;
    logic                        handshake;
    logic [DATA_WIDTH-1:0]       grant_word;

    rr_pick #(
        .N_REQ (N_REQ),
        .TAG_W (TAG_W)
    ) u_pick (
        .req  (req_valid),
        .last (last_q),
        .pick (pick),
        .any  (pick_any)
    );

    // State register plus beat counter and output stage; reset discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_q     <= LAST_RST;
            beat_cnt_q <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    // Next-state logic: pick a grantee in IDLE, count beats and detect burst end in BURST.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        beat_inc   = beat_cnt_q + BEAT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d    = ST_BURST;
                    grant_d    = pick;
                    beat_cnt_d = '0;
                end
            end
            ST_BURST: begin
                if (handshake) begin
                    beat_cnt_d = beat_inc;
                    if (beat_inc == BURST_LEN) begin
                        state_d = ST_IDLE;
                        last_d  = grant_q;
                    end
                end else if (grant_ready && !grant_valid) begin
                    // Grantee had a free slot but offered nothing: it has dropped out.
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh word refills the register even in the cycle the old one drains.
        if (handshake) begin
            out_vld_d  = 1'b1;
            out_data_d = {grant_q, grant_word};
        end else if (fifo_we) begin
            out_vld_d  = 1'b0;
        end
    end

    // Output decode: FIFO write pins, ready for the grantee only, status flags.
    always_comb begin
        fifo_we     = out_vld_q & ~fifo_full;
        grant_ready = (state_q == ST_BURST) & (~out_vld_q | fifo_we);
        req_ready   = '0;
        if (grant_ready) begin
            req_ready[grant_q] = 1'b1;
        end
        grant_valid = req_valid[grant_q];
        grant_word  = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
        handshake   = grant_ready & grant_valid;
        fifo_d      = out_data_q;
        grant_id    = grant_q;
        busy        = (state_q == ST_BURST) | out_vld_q;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (N_REQ=4, DATA_WIDTH=8, BURST=4): a per-cycle
// vector table for the single-requester burst timing, then hand-written
// sequences for reset, rotation, FIFO-full stall, dropped requester and a
// random stress run checked against per-tag scoreboards.
module tb_fifo_wr_arbiter;

    localparam int DEPTH = 16384;
    localparam int LOGD  = 16384;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_we;
    logic [9:0]  fifo_d;
    logic        fifo_full;
    logic [1:0]  grant_id;
    logic        busy;

    fifo_wr_arbiter #(
        .N_REQ      (4),
        .DATA_WIDTH (8),
        .BURST      (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_we   (fifo_we),
        .fifo_d    (fifo_d),
        .fifo_full (fifo_full),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Producer queues, scoreboard queues, write log.
    logic [7:0] prod_mem [4][DEPTH];
    int         prod_head [4];
    int         prod_tail [4];
    logic [7:0] exp_mem  [4][DEPTH];
    int         exp_head [4];
    int         exp_tail [4];
    int         wr_per   [4];
    int         gen_cnt  [4];
    bit         en       [4];
    logic [9:0] wlog [LOGD];
    int         wcnt;
    int         hs_cnt;

    typedef struct {
        logic [3:0] vld;
        logic [7:0] d0;
        logic [3:0] ready;
        logic       we;
        logic [9:0] d;
        logic [1:0] gid;
        logic       busy;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d);
        prod_mem[i][prod_tail[i] % DEPTH] = d;
        prod_tail[i]++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            prod_head[i] = 0; prod_tail[i] = 0;
            exp_head[i]  = 0; exp_tail[i]  = 0;
            wr_per[i]    = 0; gen_cnt[i]   = 0;
            en[i]        = 1'b0;
        end
        wcnt   = 0;
        hs_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive from producer queues, observe at negedge+1, advance.
    task automatic cycle();
        int t;
        for (int i = 0; i < 4; i++) begin
            if (en[i] && prod_head[i] != prod_tail[i]) begin
                req_valid[i]      = 1'b1;
                req_data[i*8 +: 8] = prod_mem[i][prod_head[i] % DEPTH];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
            end
        end
        #1;
        chk("we_while_full", {31'd0, fifo_we & fifo_full}, 32'd0);
        chk("ready_onehot0", {31'd0, $onehot0(req_ready)}, 32'd1);
        if (fifo_we) begin
            t = int'(fifo_d[9:8]);
            if (wcnt < LOGD) wlog[wcnt] = fifo_d;
            wcnt++;
            wr_per[t]++;
            if (exp_head[t] == exp_tail[t]) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_extra_write: got 0x%0h, expected no pending word for tag %0d", fifo_d, t);
            end else begin
                chk("sb_word", {24'd0, fifo_d[7:0]}, {24'd0, exp_mem[t][exp_head[t] % DEPTH]});
                exp_head[t]++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                exp_mem[i][exp_tail[i] % DEPTH] = prod_mem[i][prod_head[i] % DEPTH];
                exp_tail[i]++;
                prod_head[i]++;
                hs_cnt++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h0;
        int w0;
        int pending;

        // Single requester 0, data 1..8, BURST=4: 4 writes, 1-cycle gap, 4 writes.
        vecs[0]  = '{4'b0001, 8'd1, 4'b0000, 1'b0, 10'h000, 2'd0, 1'b0};
        vecs[1]  = '{4'b0001, 8'd1, 4'b0001, 1'b0, 10'h000, 2'd0, 1'b1};
        vecs[2]  = '{4'b0001, 8'd2, 4'b0001, 1'b1, 10'h001, 2'd0, 1'b1};
        vecs[3]  = '{4'b0001, 8'd3, 4'b0001, 1'b1, 10'h002, 2'd0, 1'b1};
        vecs[4]  = '{4'b0001, 8'd4, 4'b0001, 1'b1, 10'h003, 2'd0, 1'b1};
        vecs[5]  = '{4'b0001, 8'd5, 4'b0000, 1'b1, 10'h004, 2'd0, 1'b1};
        vecs[6]  = '{4'b0001, 8'd5, 4'b0001, 1'b0, 10'h004, 2'd0, 1'b1};
        vecs[7]  = '{4'b0001, 8'd6, 4'b0001, 1'b1, 10'h005, 2'd0, 1'b1};
        vecs[8]  = '{4'b0001, 8'd7, 4'b0001, 1'b1, 10'h006, 2'd0, 1'b1};
        vecs[9]  = '{4'b0001, 8'd8, 4'b0001, 1'b1, 10'h007, 2'd0, 1'b1};
        vecs[10] = '{4'b0000, 8'd0, 4'b0000, 1'b1, 10'h008, 2'd0, 1'b1};
        vecs[11] = '{4'b0000, 8'd0, 4'b0000, 1'b0, 10'h008, 2'd0, 1'b0};

        // ---- Reset mid-burst with a word held ----
        do_reset();
        en[0] = 1'b1;
        push(0, 8'h11);
        push(0, 8'h12);
        cycle();
        cycle();
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_we",    {31'd0, fifo_we},   32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_d",     {22'd0, fifo_d},    32'd0);
        chk("rst_gid",   {30'd0, grant_id},  32'd0);
        $display("reset mid-burst: we=%0b busy=%0b ready=%b", fifo_we, busy, req_ready);
        do_reset();
        repeat (4) cycle();
        chk("rst_no_write", wcnt, 0);

        // ---- Table: single requester burst timing ----
        do_reset();
        for (int v = 0; v < 12; v++) begin
            req_valid = vecs[v].vld;
            req_data  = {24'd0, vecs[v].d0};
            #1;
            $display("vec %0d: ready=%b we=%0b d=0x%0h gid=%0d busy=%0b", v, req_ready, fifo_we, fifo_d, grant_id, busy);
            chk("vec_ready", {28'd0, req_ready}, {28'd0, vecs[v].ready});
            chk("vec_we",    {31'd0, fifo_we},   {31'd0, vecs[v].we});
            chk("vec_d",     {22'd0, fifo_d},    {22'd0, vecs[v].d});
            chk("vec_gid",   {30'd0, grant_id},  {30'd0, vecs[v].gid});
            chk("vec_busy",  {31'd0, busy},      {31'd0, vecs[v].busy});
            @(negedge clk);
        end

        // ---- All four valid: grants rotate 0,1,2,3 a burst at a time ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            en[i] = 1'b1;
            for (int k = 0; k < 8; k++) push(i, 8'(i*64 + k));
        end
        for (int c = 0; c < 300 && wcnt < 32; c++) cycle();
        chk("rot_count", wcnt, 32);
        for (int j = 0; j < 32 && j < wcnt; j++) begin
            int r;
            int k;
            r = (j / 4) % 4;
            k = (j / 16) * 4 + j % 4;
            $display("rot write %0d: 0x%0h", j, wlog[j]);
            chk("rot_word", {22'd0, wlog[j]}, {22'd0, 2'(r), 8'(r*64 + k)});
        end

        // ---- FIFO full for 10 cycles mid-stream ----
        do_reset();
        en[1] = 1'b1;
        for (int k = 0; k < 12; k++) push(1, 8'(8'h40 + k));
        repeat (5) cycle();
        fifo_full = 1'b1;
        h0 = hs_cnt;
        w0 = wcnt;
        repeat (10) cycle();
        chk("full_no_write", wcnt - w0, 0);
        chk("full_buffered_le1", {31'd0, (hs_cnt - h0) <= 1}, 32'd1);
        fifo_full = 1'b0;
        for (int c = 0; c < 100 && wcnt < 12; c++) cycle();
        chk("full_count", wcnt, 12);
        for (int k = 0; k < 12 && k < wcnt; k++) begin
            $display("full write %0d: 0x%0h", k, wlog[k]);
            chk("full_word", {22'd0, wlog[k]}, {22'd0, 2'd1, 8'(8'h40 + k)});
        end

        // ---- Requester 2 drops after 2 beats, 3 waiting ----
        do_reset();
        en[2] = 1'b1;
        en[3] = 1'b1;
        push(2, 8'h80); push(2, 8'h81);
        for (int k = 0; k < 4; k++) push(3, 8'(8'hC0 + k));
        for (int c = 0; c < 60 && wcnt < 6; c++) cycle();
        chk("drop_count", wcnt, 6);
        chk("drop_gid", {30'd0, grant_id}, 32'd3);
        for (int j = 0; j < 6 && j < wcnt; j++) begin
            logic [9:0] e;
            e = (j < 2) ? {2'd2, 8'(8'h80 + j)} : {2'd3, 8'(8'hC0 + j - 2)};
            $display("drop write %0d: 0x%0h", j, wlog[j]);
            chk("drop_word", {22'd0, wlog[j]}, {22'd0, e});
        end

        // ---- Rotating priority beats index order ----
        do_reset();
        en[0] = 1'b1;
        en[1] = 1'b1;
        push(0, 8'h05);
        repeat (6) cycle();
        push(0, 8'h06);
        push(1, 8'h07);
        for (int c = 0; c < 40 && wcnt < 3; c++) cycle();
        chk("prio_count", wcnt, 3);
        chk("prio_first",  {22'd0, wlog[1]}, {22'd0, 2'd1, 8'h07});
        chk("prio_second", {22'd0, wlog[2]}, {22'd0, 2'd0, 8'h06});
        $display("priority writes: 0x%0h 0x%0h 0x%0h", wlog[0], wlog[1], wlog[2]);

        // ---- Random valid/full stress ----
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                en[i] = ($urandom_range(0, 3) != 0);
                if (prod_tail[i] - prod_head[i] < 3) begin
                    push(i, 8'(gen_cnt[i]));
                    gen_cnt[i]++;
                end
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            cycle();
        end
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) en[i] = 1'b1;
        pending = 1;
        for (int c = 0; c < 1000 && pending != 0; c++) begin
            cycle();
            pending = 0;
            for (int i = 0; i < 4; i++)
                pending += (prod_tail[i] - prod_head[i]) + (exp_tail[i] - exp_head[i]);
        end
        for (int i = 0; i < 4; i++) begin
            $display("stress tag %0d: generated %0d written %0d", i, gen_cnt[i], wr_per[i]);
            chk("stress_left_sb",   exp_tail[i] - exp_head[i], 0);
            chk("stress_left_prod", prod_tail[i] - prod_head[i], 0);
            chk("stress_total",     wr_per[i], gen_cnt[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
